// File: rtl/in_fifo_pkg.sv
// rtl/in_fifo_pkg.sv - shared types and helpers for the USB full-speed IN FIFO
package in_fifo_pkg;

  // SIE-side packet states
  typedef enum logic [1:0] {
    ST_IN_IDLE     = 2'd0,
    ST_IN_DATA     = 2'd1,
    ST_IN_WAIT_ACK = 2'd2
  } in_state_e;

  // Bits needed to index 'value' entries; never less than one bit
  function automatic int ceil_log2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/in_fifo.sv
// rtl/in_fifo.sv - USB full-speed IN FIFO with retransmit until host ACK
module in_fifo
  import in_fifo_pkg::*;
#(
  parameter int IN_MAXPACKETSIZE = 8,
  parameter int BIT_SAMPLES      = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] app_in_data_i,
  input  logic       app_in_valid_i,
  output logic       app_in_ready_o,
  output logic       in_empty_o,
  output logic       in_full_o,
  input  logic       in_req_i,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  output logic       in_nak_o,
  input  logic       in_ready_i,
  input  logic       in_data_ack_i
);

  // One spare slot distinguishes full from empty
  localparam int IN_LENGTH = IN_MAXPACKETSIZE + 1;
  localparam int PTR_W     = ceil_log2(IN_LENGTH);
  localparam int CNT_W     = ceil_log2(IN_MAXPACKETSIZE + 1);
  localparam int DLY_W     = ceil_log2(BIT_SAMPLES);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(IN_LENGTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(IN_MAXPACKETSIZE);
  localparam logic [DLY_W-1:0] DLY_MAX  = DLY_W'(BIT_SAMPLES - 1);

  // Circular pointer increment
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  logic [7:0]       mem_q [IN_LENGTH];
  logic [PTR_W-1:0] in_last_q;     // next write slot
  logic [PTR_W-1:0] in_first_q;    // oldest byte not yet ACKed
  logic [PTR_W-1:0] in_first_qq_q; // next byte to send in current packet
  logic [PTR_W-1:0] in_end_q;      // write pointer captured at IN token
  logic [PTR_W-1:0] in_last_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DLY_W-1:0] dly_q;
  in_state_e        state_q;
  logic             nak_q;
  logic             full;
  logic             app_accept;
  logic             in_valid;

  assign in_last_d      = ptr_next(in_last_q);
  // Full is judged against the committed pointer so unACKed bytes survive
  assign full           = (in_last_d == in_first_q);
  assign in_full_o      = full;
  assign in_empty_o     = (in_last_q == in_first_q);
  assign app_in_ready_o = (dly_q == DLY_MAX) && !full;
  assign app_accept     = app_in_valid_i && app_in_ready_o;

  assign in_valid   = (state_q == ST_IN_DATA) && (in_first_qq_q != in_end_q) && (cnt_q < CNT_MAX);
  assign in_valid_o = in_valid;
  assign in_data_o  = mem_q[in_first_qq_q];
  assign in_nak_o   = nak_q;

  // Application writes, paced to at most one byte per bit time
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < IN_LENGTH; i++) begin
        mem_q[i] <= 8'd0;
      end
      in_last_q <= '0;
      dly_q     <= '0;
    end else if (app_accept) begin
      mem_q[in_last_q] <= app_in_data_i;
      in_last_q        <= in_last_d;
      dly_q            <= '0;
    end else if (dly_q != DLY_MAX) begin
      dly_q <= dly_q + DLY_W'(1);
    end
  end

  // SIE packet sequencing: IN token rewinds, ready steps, ACK commits
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IN_IDLE;
      in_first_q    <= '0;
      in_first_qq_q <= '0;
      in_end_q      <= '0;
      cnt_q         <= '0;
      nak_q         <= 1'b0;
    end else if (in_req_i) begin
      in_first_qq_q <= in_first_q;
      in_end_q      <= in_last_q;
      cnt_q         <= '0;
      if (in_last_q == in_first_q) begin
        nak_q   <= 1'b1;
        state_q <= ST_IN_IDLE;
      end else begin
        nak_q   <= 1'b0;
        state_q <= ST_IN_DATA;
      end
    end else begin
      case (state_q)
        ST_IN_DATA: begin
          if (in_ready_i) begin
            if (in_valid) begin
              in_first_qq_q <= ptr_next(in_first_qq_q);
              cnt_q         <= cnt_q + CNT_W'(1);
            end else begin
              state_q <= ST_IN_WAIT_ACK;
            end
          end
        end
        ST_IN_WAIT_ACK: begin
          if (in_data_ack_i) begin
            in_first_q <= in_first_qq_q;
            state_q    <= ST_IN_IDLE;
          end
        end
        default: begin
          state_q <= ST_IN_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_in_fifo.sv
// tb/tb_in_fifo.sv - self-checking bench for in_fifo against a queue model
module tb_in_fifo;

  logic       clk;
  logic       rstn;
  logic [7:0] app_data;
  logic       app_valid;
  logic       app_ready;
  logic       in_empty;
  logic       in_full;
  logic       in_req;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_nak;
  logic       in_ready;
  logic       in_ack;

  int vectors;
  int miscompares;

  // Model: bytes held and not yet acknowledged, oldest first
  logic [7:0] mq[$];
  int         since;
  int         pkt_n;
  int         sent;
  int         mst;   // 0 idle, 1 sending, 2 awaiting ack
  bit         mnak;
  bit         last_wrote;

  in_fifo #(
    .IN_MAXPACKETSIZE(8),
    .BIT_SAMPLES(4)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .app_in_data_i(app_data),
    .app_in_valid_i(app_valid),
    .app_in_ready_o(app_ready),
    .in_empty_o(in_empty),
    .in_full_o(in_full),
    .in_req_i(in_req),
    .in_data_o(in_data),
    .in_valid_o(in_valid),
    .in_nak_o(in_nak),
    .in_ready_i(in_ready),
    .in_data_ack_i(in_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (since >= 3) && (mq.size() < 8);
  endfunction

  task automatic model_reset();
    mq.delete();
    since = 0; pkt_n = 0; sent = 0; mst = 0; mnak = 0;
  endtask

  task automatic check_all();
    bit ev;
    ev = (mst == 1) && (sent < pkt_n);
    chk("in_valid", {7'd0, in_valid}, {7'd0, ev});
    chk("in_nak", {7'd0, in_nak}, {7'd0, mnak});
    chk("in_empty", {7'd0, in_empty}, {7'd0, mq.size() == 0});
    chk("in_full", {7'd0, in_full}, {7'd0, mq.size() == 8});
    chk("app_ready", {7'd0, app_ready}, {7'd0, m_ready()});
    if (ev) chk("in_data", in_data, mq[sent]);
  endtask

  // One clock: model advances with the inputs present at the edge
  task automatic cycle();
    bit acc, emp, r, rd, ak;
    logic [7:0] d;
    acc = app_valid && m_ready();
    emp = (mq.size() == 0);
    r = in_req; rd = in_ready; ak = in_ack; d = app_data;
    @(posedge clk);
    if (r) begin
      sent = 0;
      if (emp) begin mnak = 1; mst = 0; end
      else begin mnak = 0; pkt_n = (mq.size() < 8) ? mq.size() : 8; mst = 1; end
    end else if (mst == 1 && rd) begin
      if (sent < pkt_n) sent++;
      else mst = 2;
    end else if (mst == 2 && ak) begin
      for (int k = 0; k < sent; k++) void'(mq.pop_front());
      mst = 0;
    end
    if (acc) begin mq.push_back(d); since = 0; end
    else if (since < 3) since++;
    last_wrote = acc;
    #1;
    check_all();
  endtask

  task automatic push_byte(input logic [7:0] b);
    app_valid = 1'b1; app_data = b;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_wrote) break;
    end
    chk("push_accepted", {7'd0, last_wrote}, 8'd1);
    app_valid = 1'b0;
  endtask

  task automatic pulse_req();   in_req = 1'b1;   cycle(); in_req = 1'b0;   endtask
  task automatic pulse_ready(); in_ready = 1'b1; cycle(); in_ready = 1'b0; endtask
  task automatic pulse_ack();   in_ack = 1'b1;   cycle(); in_ack = 1'b0;   endtask

  task automatic do_reset();
    in_req = 0; in_ready = 0; in_ack = 0; app_valid = 0;
    @(posedge clk); #3;
    rstn = 1'b0;
    #1;
    chk("rst_valid", {7'd0, in_valid}, 8'd0);
    chk("rst_nak", {7'd0, in_nak}, 8'd0);
    chk("rst_empty", {7'd0, in_empty}, 8'd1);
    chk("rst_full", {7'd0, in_full}, 8'd0);
    chk("rst_ready", {7'd0, app_ready}, 8'd0);
    chk("rst_data", in_data, 8'd0);
    model_reset();
    @(posedge clk); #1;
    rstn = 1'b1;
    cycle(); cycle();
    chk("rst_ready_2clk", {7'd0, app_ready}, 8'd0);
    cycle();
    chk("rst_ready_3clk", {7'd0, app_ready}, 8'd1);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rstn = 1'b0; app_data = 8'd0; app_valid = 0;
    in_req = 0; in_ready = 0; in_ack = 0;
    model_reset();
    do_reset();

    // Reset mid-packet
    push_byte(8'h77); push_byte(8'h88);
    pulse_req(); pulse_ready();
    do_reset();

    // Three-byte packet then ACK
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3);
    pulse_req();
    chk("t2_b0", in_data, 8'hA1);
    pulse_ready(); chk("t2_b1", in_data, 8'hA2);
    pulse_ready(); chk("t2_b2", in_data, 8'hA3);
    pulse_ready(); chk("t2_end", {7'd0, in_valid}, 8'd0);
    pulse_ready();
    pulse_ack();   chk("t2_empty", {7'd0, in_empty}, 8'd1);

    // Retransmit when ACK is missing
    push_byte(8'h11); push_byte(8'h22);
    pulse_req(); pulse_ready(); pulse_ready(); pulse_ready();
    pulse_req(); chk("t3_re0", in_data, 8'h11);
    pulse_ready(); chk("t3_re1", in_data, 8'h22);
    pulse_ready(); pulse_ready();
    pulse_ack(); chk("t3_empty", {7'd0, in_empty}, 8'd1);

    // NAK on empty, then a one-byte packet
    pulse_req();
    chk("t4_nak", {7'd0, in_nak}, 8'd1);
    chk("t4_novalid", {7'd0, in_valid}, 8'd0);
    push_byte(8'h5A);
    pulse_req();
    chk("t4_nak_clr", {7'd0, in_nak}, 8'd0);
    chk("t4_data", in_data, 8'h5A);
    pulse_ready(); pulse_ready(); pulse_ack();

    // Fill to capacity; ninth byte waits for the ACK
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    chk("t5_full", {7'd0, in_full}, 8'd1);
    chk("t5_notready", {7'd0, app_ready}, 8'd0);
    app_valid = 1'b1; app_data = 8'h09;
    cycle(); cycle(); cycle();
    pulse_req();
    for (int i = 1; i <= 8; i++) begin
      chk("t5_byte", in_data, 8'(i));
      pulse_ready();
    end
    chk("t5_end", {7'd0, in_valid}, 8'd0);
    pulse_ready();
    pulse_ack();
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (last_wrote) break;
    end
    chk("t5_9th", {7'd0, last_wrote}, 8'd1);
    app_valid = 1'b0;
    pulse_req(); chk("t5_9th_data", in_data, 8'h09);
    pulse_ready(); pulse_ready(); pulse_ack();

    // Byte written during DATA belongs to the next packet
    push_byte(8'h01); push_byte(8'h02);
    pulse_req();
    push_byte(8'h03);
    chk("t6_b0", in_data, 8'h01);
    pulse_ready(); chk("t6_b1", in_data, 8'h02);
    pulse_ready(); chk("t6_end", {7'd0, in_valid}, 8'd0);
    pulse_ready(); pulse_ack();
    chk("t6_notempty", {7'd0, in_empty}, 8'd0);
    pulse_req(); chk("t6_next", in_data, 8'h03);
    pulse_ready(); pulse_ready(); pulse_ack();

    // Random traffic, including retried tokens and stray ACKs
    for (int i = 0; i < 600; i++) begin
      if (!app_valid && $urandom_range(0, 1) == 1) begin
        app_valid = 1'b1; app_data = 8'($urandom);
      end
      in_req   = ($urandom_range(0, 15) == 0);
      in_ready = ($urandom_range(0, 2) == 0);
      in_ack   = ($urandom_range(0, 3) == 0);
      cycle();
      if (last_wrote) app_valid = 1'b0;
      in_req = 0; in_ready = 0; in_ack = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
